cmp_unit: RTL and testbench
===========================

CMP_UNIT -- requirements
Module: cmp_unit

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand and result width in bits (legal 8..64).
REQ-002 SHALL provide parameter STAGES, default 1, pipeline depth in register stages (legal 1..4).
REQ-003 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1, operand set present.
REQ-006 SHALL have port in_ready, output, 1, unit accepts operands this cycle.
REQ-007 SHALL have port op, input, 3, compare operation, RISC-V funct3 encoding.
REQ-008 SHALL have port a, input, WIDTH, first operand.
REQ-009 SHALL have port b, input, WIDTH, second operand.
REQ-010 SHALL have port flush, input, 1, discard all in-flight operations.
REQ-011 SHALL have port out_valid, output, 1, result present.
REQ-012 SHALL have port out_ready, input, 1, consumer takes result this cycle.
REQ-013 SHALL have port result, output, WIDTH, compare outcome zero-extended (0 or 1).
REQ-014 SHALL have port taken, output, 1, compare outcome as single bit (equals result[0]).

Function
REQ-015 SHALL decode op: 000 a==b; 001 a!=b; 100 and 010 signed a<b; 101 signed a>=b; 110 and 011 unsigned a<b; 111 unsigned a>=b.
REQ-016 SHALL treat signed ops as two's complement over full WIDTH; unsigned ops as plain magnitude.
REQ-017 SHALL capture an operation when in_valid and in_ready are both high (accept).
REQ-018 SHALL define advance = !out_valid || out_ready; in_ready SHALL equal advance while flush is low, and SHALL be low whenever flush is high.
REQ-019 SHALL move every stage (data and valid bit) forward by one on each advance cycle; all stages hold when advance is low.
REQ-020 SHALL insert a bubble (valid 0) into stage 1 on an advance cycle without accept.
REQ-021 SHALL present an accepted operation's outcome on result/taken with out_valid high exactly STAGES cycles after accept when advance stays high.
REQ-022 SHALL sustain one accept per cycle with out_ready held high (full throughput, no bubbles).
REQ-023 SHALL keep result, taken, out_valid stable while out_valid is high and out_ready is low.
REQ-024 SHALL drive result and taken to 0 whenever out_valid is low.
REQ-025 SHALL, on flush high, clear all stage valid bits at that edge, drop any input offered that cycle, and drop the result present that cycle even if out_ready is high.
REQ-026 SHALL give rst priority over flush and over accept.

Reset
REQ-027 SHALL, at a clock edge with rst high, clear all stage valid bits and data registers, regardless of operations in flight.
REQ-028 SHALL hold out_valid=0, result=0, taken=0 during and after reset until a new result arrives; in_ready=1 on the first cycle after rst falls.

Verification
REQ-029 SHALL cover, WIDTH=32, STAGES=1: op=100, a=0xFFFFFFFF, b=0x00000001 -> next cycle out_valid=1, result=1; same operands with op=110 -> result=0.
REQ-030 SHALL cover, STAGES=3: op=000, a=b=0x12345678 accepted at cycle 0 -> out_valid=1, taken=1 at cycle 3, out_valid=0 at cycles 1-2.
REQ-031 SHALL cover backpressure, STAGES=2: four back-to-back accepts, out_ready low cycles 3-5 -> in_ready low those cycles, first result held stable, all four results delivered in order, none lost or duplicated.
REQ-032 SHALL cover flush, STAGES=3: three operations in flight, flush for one cycle -> out_valid=0 for next three cycles; operation offered with flush is not delivered.
REQ-033 SHALL cover reset mid-operation: rst high one cycle with two results in flight -> out_valid=0, result=0 next cycle, in_ready=1.
REQ-034 SHALL cover WIDTH=8 boundaries: op=101, a=0x80, b=0x7F -> result=0; op=111 same operands -> result=1; op=001, a=b=0x00 -> result=0.

Source files
------------

// File: rtl/cmp_unit.sv
// Pipelined RISC-V style comparator: evaluates a funct3 compare on accept and carries
// the one-bit outcome through STAGES registers under valid/ready flow control.
module cmp_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             taken
);

  logic [STAGES-1:0] vld;
  logic [STAGES-1:0] bit_q;
  logic              advance;
  logic              accept;
  logic              cmp;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !flush;
  assign accept   = in_valid && in_ready;

  // funct3 decode; 010/011 alias the signed/unsigned less-than forms
  always_comb begin
    cmp = 1'b0;
    case (op)
      3'b000:         cmp = (a == b);
      3'b001:         cmp = (a != b);
      3'b100, 3'b010: cmp = ($signed(a) <  $signed(b));
      3'b101:         cmp = ($signed(a) >= $signed(b));
      3'b110, 3'b011: cmp = (a <  b);
      3'b111:         cmp = (a >= b);
      default:        cmp = 1'b0;
    endcase
  end

  // Outcome bits are only ever set alongside a valid bit, so idle stages read as zero
  always_ff @(posedge clk) begin
    if (rst) begin
      vld   <= '0;
      bit_q <= '0;
    end else if (flush) begin
      vld   <= '0;
      bit_q <= '0;
    end else if (advance) begin
      vld   <= STAGES'({vld, accept});
      bit_q <= STAGES'({bit_q, accept & cmp});
    end
  end

  assign out_valid = vld[STAGES-1];
  assign taken     = bit_q[STAGES-1];
  assign result    = WIDTH'(bit_q[STAGES-1]);

endmodule

// File: tb/tb_cmp_unit.sv
// Directed plus random bench for cmp_unit across four width/depth configurations,
// checked by per-instance scoreboards and directed latency/stall/flush/reset checks.
module tb_cmp_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [2:0]  op;
  logic [63:0] a;
  logic [63:0] b;
  logic        flush;
  logic        out_ready;

  logic        ov [4];
  logic        tk [4];
  logic        ir [4];
  logic [63:0] res [4];
  int          qsize [4];

  int passed = 0;
  int total  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic ref_cmp(input logic [2:0] o, input logic [63:0] x,
                                   input logic [63:0] y, input int unsigned w);
    logic [63:0] ux, uy;
    longint      sx, sy;
    ux = (x << (64 - w)) >> (64 - w);
    uy = (y << (64 - w)) >> (64 - w);
    sx = $signed(x << (64 - w)) >>> (64 - w);
    sy = $signed(y << (64 - w)) >>> (64 - w);
    case (o)
      3'd0:       return ux == uy;
      3'd1:       return ux != uy;
      3'd4, 3'd2: return sx <  sy;
      3'd5:       return sx >= sy;
      3'd6, 3'd3: return ux <  uy;
      default:    return ux >= uy;
    endcase
  endfunction

  // Instances: u0 W32/S1, u1 W32/S2, u2 W32/S3, u3 W8/S1
  for (genvar g = 0; g < 4; g++) begin : gen_u
    localparam int unsigned W_G = (g == 3) ? 8 : 32;
    localparam int unsigned S_G = (g == 3) ? 1 : g + 1;
    logic [W_G-1:0] r;
    logic           q [$];
    logic           e;

    cmp_unit #(.WIDTH(W_G), .STAGES(S_G)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (ir[g]),
      .op        (op),
      .a         (a[W_G-1:0]),
      .b         (b[W_G-1:0]),
      .flush     (flush),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .result    (r),
      .taken     (tk[g])
    );
    assign res[g] = 64'(r);

    // Scoreboard: push on accept, pop on delivery, drop everything on flush/reset
    always @(negedge clk) begin
      if (rst) begin
        q.delete();
      end else begin
        if (!ov[g]) chk($sformatf("u%0d idle_zero", g), res[g] | 64'(tk[g]), 64'd0);
        if (ov[g] && out_ready && !flush) begin
          chk($sformatf("u%0d expected_pending", g), 64'(q.size() != 0), 64'd1);
          if (q.size() != 0) begin
            e = q.pop_front();
            chk($sformatf("u%0d result", g), res[g], 64'(e));
            chk($sformatf("u%0d taken", g), 64'(tk[g]), 64'(e));
          end
        end
        if (flush) q.delete();
        else if (in_valid && ir[g]) q.push_back(ref_cmp(op, a, b, W_G));
      end
      qsize[g] = q.size();
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] o, input logic [63:0] x, input logic [63:0] y);
    in_valid = v;
    op       = o;
    a        = x;
    b        = y;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 3'd0, 64'd0, 64'd0);
    step(); step();
    rst = 1'b0;
    #1;
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("u%0d reset out_valid", g), 64'(ov[g]), 64'd0);
      chk($sformatf("u%0d reset result", g), res[g], 64'd0);
      chk($sformatf("u%0d reset taken", g), 64'(tk[g]), 64'd0);
      chk($sformatf("u%0d reset in_ready", g), 64'(ir[g]), 64'd1);
    end
    step();

    // Signed vs unsigned less-than on all-ones, single stage
    drive(1'b1, 3'b100, 64'hFFFF_FFFF, 64'h1);
    step();
    chk("slt out_valid", 64'(ov[0]), 64'd1);
    chk("slt result", res[0], 64'd1);
    drive(1'b1, 3'b110, 64'hFFFF_FFFF, 64'h1);
    step();
    chk("sltu out_valid", 64'(ov[0]), 64'd1);
    chk("sltu result", res[0], 64'd0);
    drive(1'b0, 3'd0, 64'd0, 64'd0);
    repeat (5) step();

    // Three-stage latency
    drive(1'b1, 3'b000, 64'h1234_5678, 64'h1234_5678);
    step();
    drive(1'b0, 3'd0, 64'd0, 64'd0);
    chk("lat3 cycle1 out_valid", 64'(ov[2]), 64'd0);
    step();
    chk("lat3 cycle2 out_valid", 64'(ov[2]), 64'd0);
    step();
    chk("lat3 cycle3 out_valid", 64'(ov[2]), 64'd1);
    chk("lat3 cycle3 taken", 64'(tk[2]), 64'd1);
    repeat (5) step();

    // Backpressure on the two-stage unit: outcomes 0,1,0,1, stall cycles 3-5
    drive(1'b1, 3'b001, 64'd7, 64'd7); step();
    drive(1'b1, 3'b000, 64'd9, 64'd9); step();
    drive(1'b1, 3'b111, 64'd3, 64'd5); step();
    drive(1'b1, 3'b110, 64'd3, 64'd5);
    out_ready = 1'b0;
    for (int c = 3; c <= 5; c++) begin
      #1;
      chk($sformatf("bp c%0d in_ready", c), 64'(ir[1]), 64'd0);
      chk($sformatf("bp c%0d out_valid", c), 64'(ov[1]), 64'd1);
      chk($sformatf("bp c%0d held result", c), res[1], 64'd1);
      chk($sformatf("bp c%0d held taken", c), 64'(tk[1]), 64'd1);
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("bp c6 in_ready", 64'(ir[1]), 64'd1);
    step();
    drive(1'b0, 3'd0, 64'd0, 64'd0);
    repeat (6) step();

    // Flush with three in flight on the three-stage unit
    drive(1'b1, 3'b000, 64'd1, 64'd1); step();
    drive(1'b1, 3'b001, 64'd1, 64'd2); step();
    drive(1'b1, 3'b101, 64'd4, 64'd2); step();
    drive(1'b1, 3'b000, 64'd5, 64'd5);
    flush = 1'b1;
    #1;
    chk("flush in_ready", 64'(ir[2]), 64'd0);
    chk("flush out_valid before", 64'(ov[2]), 64'd1);
    step();
    flush = 1'b0;
    drive(1'b0, 3'd0, 64'd0, 64'd0);
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("flush +%0d out_valid", c), 64'(ov[2]), 64'd0);
      step();
    end
    repeat (3) step();

    // Reset with two operations in flight
    drive(1'b1, 3'b000, 64'd6, 64'd6); step();
    drive(1'b1, 3'b111, 64'd8, 64'd2); step();
    drive(1'b0, 3'd0, 64'd0, 64'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    for (int g = 1; g < 3; g++) begin
      chk($sformatf("u%0d midrst out_valid", g), 64'(ov[g]), 64'd0);
      chk($sformatf("u%0d midrst result", g), res[g], 64'd0);
      chk($sformatf("u%0d midrst in_ready", g), 64'(ir[g]), 64'd1);
    end
    repeat (2) step();

    // Eight-bit boundaries
    drive(1'b1, 3'b101, 64'h80, 64'h7F); step();
    chk("w8 sge result", res[3], 64'd0);
    drive(1'b1, 3'b111, 64'h80, 64'h7F); step();
    chk("w8 sgeu result", res[3], 64'd1);
    drive(1'b1, 3'b001, 64'h00, 64'h00); step();
    chk("w8 ne result", res[3], 64'd0);
    chk("w8 ne out_valid", 64'(ov[3]), 64'd1);
    drive(1'b0, 3'd0, 64'd0, 64'd0);
    repeat (3) step();

    // Random traffic with backpressure and occasional flush
    for (int i = 0; i < 300; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 255)) : 64'($urandom);
      b = ($urandom_range(0, 3) == 0) ? a : 64'($urandom);
      op        = 3'($urandom);
      in_valid  = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 20) == 0);
      step();
    end
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 3'd0, 64'd0, 64'd0);
    repeat (8) step();
    for (int g = 0; g < 4; g++)
      chk($sformatf("u%0d drained", g), 64'(qsize[g]), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
